uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Parametrised UART receiver for the SoC peripheral set.
- Supports configurable payload width, optional even or odd parity, and 1 or 2 stop bits.
- Rejects false start bits, and flags parity errors, framing errors and breaks per frame.
- Buffers received frames in a first-word-fall-through FIFO with a valid/ready output handshake and a sticky overrun flag, so APB-side logic can drain it at its own pace.

Parameters:
- CLK_HZ, 10_000_000: system clock frequency in Hz.
- BIT_RATE, 115200: baud rate. CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer division, must be at least 8). MID = CYCLES_PER_BIT/2.
- PAYLOAD_BITS, 8: data bits per frame, range 5..9.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- PARITY_EN, 0: 1 means a parity bit follows the data bits.
- PARITY_ODD, 0: 0 means even parity, 1 means odd parity. Ignored when PARITY_EN=0.
- FIFO_DEPTH, 4: number of frame entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- uart_rxd  in  1  asynchronous serial input, idles high
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  consumer accepts the head entry
- rx_data  out  PAYLOAD_BITS  head entry data, LSB = first received bit
- rx_parity_err  out  1  head entry had a parity mismatch
- rx_frame_err  out  1  head entry had a 0 sampled in a stop bit
- rx_break  out  1  head entry is a break
- rx_overrun  out  1  sticky: a frame was dropped because the FIFO was full
- overrun_clr  in  1  one-cycle pulse that clears rx_overrun
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries

Behaviour:
- Reset values:
  - Synchroniser = 2'b11.
  - FSM = IDLE.
  - FIFO empty, so rx_valid=0 and fifo_level=0.
  - rx_overrun=0.
  - rx_data and all error outputs = 0.
- Reset mid-frame aborts the frame and discards it. After reset, a start is recognised only on a fresh high-to-low edge.
- Input synchronisation: uart_rxd passes through a 2-FF synchroniser. The FSM uses only the synchronised value and its previous value.
- Bit-timing counter: cleared on every state entry, increments every cycle.
- IDLE: a synchronised falling edge (previous=1, current=0) moves to START.
- START:
  - At cnt==MID, sample the line.
  - Sample 1: false start, return to IDLE with no push.
  - Sample 0: go to DATA with the counter cleared.
- Sample points in all later states: cnt==CYCLES_PER_BIT-1, after which the counter wraps to 0.
- DATA:
  - Shift in PAYLOAD_BITS samples, LSB first.
  - Then go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: take one sample.
  - parity_err = (XOR of data bits XOR parity sample) != PARITY_ODD.
  - When PARITY_EN=0, parity_err is always 0.
- STOP:
  - Take STOP_BITS samples. frame_err=1 if any stop sample is 0.
  - After the last stop sample, push {break, frame_err, parity_err, data} and go to IDLE in the same cycle.
- Break detection:
  - break=1 when frame_err=1, all data bits are 0, and the parity sample (if present) is 0.
  - A break pushes one entry with data=0, frame_err=1 and break=1.
  - The FSM then goes to BRKWAIT instead of IDLE, and stays there until the synchronised line reads 1, then goes to IDLE.
  - A long break therefore never produces a second frame.
- FIFO:
  - Push is registered: rx_valid rises 1 cycle after the final stop-bit sample cycle.
  - The head entry drives rx_data and the error outputs combinationally from storage.
  - Pop occurs when rx_valid && rx_ready.
  - rx_ready while empty has no effect.
- Full and overrun:
  - Push while full and no pop in the same cycle: the new frame is dropped, rx_overrun is set, FIFO contents are unchanged.
  - Simultaneous push and pop while full: both take effect, fifo_level stays at FIFO_DEPTH, no overrun.
  - Simultaneous push and pop while empty: only the push takes effect, since rx_valid was 0.
- Overrun flag:
  - rx_overrun holds until overrun_clr.
  - If set and clear occur in the same cycle, set wins.
- Pointer arithmetic: read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. fifo_level is updated with each push and pop.

Test Plan:
- Timing check with defaults (86 cycles/bit, MID=43), 8N1, rx_ready=1:
  - Stimulus: uart_rxd falls at cycle 0, transmitting 0xA5.
  - Required: rx_valid=1 for exactly 1 cycle at cycle 821±2, rx_data=0xA5, all error outputs 0.
- Parity, PARITY_EN=1, PARITY_ODD=0:
  - Send 0x01 with parity bit 1 → data 0x01, rx_parity_err=0.
  - Send 0x01 with parity bit 0 → rx_parity_err=1.
- Framing error and break:
  - Send 0x3C with a 0 stop bit → rx_frame_err=1, rx_break=0.
  - Hold uart_rxd low for 12 bit-times, then release → exactly one entry: data 0x00, rx_frame_err=1, rx_break=1. Following idle-high time produces no further entry.
- Glitch rejection: drive uart_rxd low for 20 cycles, then high → no push, fifo_level stays 0, FSM back in IDLE.
- Overrun, FIFO_DEPTH=4, rx_ready=0:
  - Send 0x10..0x14 → fifo_level=4, rx_overrun=1.
  - Then set rx_ready=1 → pops return 0x10, 0x11, 0x12, 0x13, and rx_valid=0 after that.
  - Pulse overrun_clr → rx_overrun=0.
  - Variant: pulse overrun_clr in the same cycle as a further dropped push → rx_overrun stays 1.
- Reset mid-frame: assert resetn=0 for 2 cycles during data bit 3 → rx_valid=0, fifo_level=0, no partial frame pushed. A following 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-FF synchroniser, false-start rejection, parity/framing/break flags,
// feeding a first-word-fall-through frame FIFO with valid/ready drain and sticky overrun.
module uart_rx_fifo #(
   parameter int CLK_HZ       = 10_000_000,
   parameter int BIT_RATE     = 115200,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          uart_rxd,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [PAYLOAD_BITS-1:0]       rx_data,
   output logic                          rx_parity_err,
   output logic                          rx_frame_err,
   output logic                          rx_break,
   output logic                          rx_overrun,
   input  logic                          overrun_clr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int CPB = CLK_HZ / BIT_RATE;
   localparam int MID = CPB / 2;
   localparam int CW  = $clog2(CPB);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int EW  = PAYLOAD_BITS + 3;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} state_t;

   state_t                  state;
   logic [1:0]              sync;
   logic                    prev;
   logic [CW-1:0]           cnt;
   logic [3:0]              bit_cnt;
   logic [PAYLOAD_BITS-1:0] shift;
   logic                    par_bit;
   logic                    stop_cnt;
   logic                    ferr_acc;

   logic                    rxs;
   logic                    bit_tick;
   logic                    push;
   logic                    frame_err;
   logic                    parity_err;
   logic                    brk;
   logic [EW-1:0]           push_ent;

   assign rxs        = sync[1];
   assign bit_tick   = (cnt == CW'(CPB - 1));
   assign push       = (state == STOP) && bit_tick && (stop_cnt == 1'(STOP_BITS - 1));
   assign frame_err  = ferr_acc | ~rxs;
   assign parity_err = (PARITY_EN != 0) && ((^shift ^ par_bit) != 1'(PARITY_ODD));
   // A break is an all-zero frame whose stop bit also read low.
   assign brk        = frame_err && (shift == '0) && ((PARITY_EN == 0) || !par_bit);
   assign push_ent   = {brk, frame_err, parity_err, shift};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync     <= 2'b11;
         prev     <= 1'b1;
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         stop_cnt <= 1'b0;
         ferr_acc <= 1'b0;
      end else begin
         sync <= {sync[0], uart_rxd};
         prev <= rxs;
         cnt  <= bit_tick ? '0 : cnt + CW'(1);
         case (state)
            IDLE: begin
               if (prev && !rxs) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == CW'(MID)) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  state   <= rxs ? IDLE : DATA;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  shift   <= {rxs, shift[PAYLOAD_BITS-1:1]};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'(PAYLOAD_BITS - 1)) begin
                     state    <= (PARITY_EN != 0) ? PARITY : STOP;
                     stop_cnt <= 1'b0;
                     ferr_acc <= 1'b0;
                  end
               end
            end
            PARITY: begin
               if (bit_tick) begin
                  par_bit  <= rxs;
                  state    <= STOP;
                  stop_cnt <= 1'b0;
                  ferr_acc <= 1'b0;
               end
            end
            STOP: begin
               if (bit_tick) begin
                  ferr_acc <= frame_err;
                  stop_cnt <= stop_cnt + 1'b1;
                  if (push) state <= brk ? BRKWAIT : IDLE;
               end
            end
            BRKWAIT: begin
               if (rxs) begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          full;
   logic          pop;
   logic          wr;
   logic [EW-1:0] head;

   assign rx_valid = (fifo_level != '0);
   assign full     = (fifo_level == (AW+1)'(FIFO_DEPTH));
   assign pop      = rx_valid && rx_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign wr       = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (resetn && wr) mem[wptr] <= push_ent;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_level <= '0;
         rx_overrun <= 1'b0;
      end else begin
         if (wr)  wptr <= wptr + AW'(1);
         if (pop) rptr <= rptr + AW'(1);
         if (wr && !pop)      fifo_level <= fifo_level + (AW+1)'(1);
         else if (pop && !wr) fifo_level <= fifo_level - (AW+1)'(1);
         if (push && full && !pop) rx_overrun <= 1'b1;
         else if (overrun_clr)     rx_overrun <= 1'b0;
      end
   end

   assign head = rx_valid ? mem[rptr] : '0;
   assign {rx_break, rx_frame_err, rx_parity_err, rx_data} = head;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: instance 0 is the default 8N1 @ 86 cycles/bit, instance 1 is 8E2 @ 16 cycles/bit.
// Frames are scheduled into a queue model at their due cycle and compared against both DUTs every cycle.
module tb_uart_rx_fifo;
   localparam int DEPTH = 4;

   typedef struct {
      logic [7:0]  data;
      logic        pe;
      logic        fe;
      logic        brk;
      int unsigned due;
   } ent_t;

   logic       clk;
   logic       resetn;
   logic       rxd [2];
   logic       rdy [2];
   logic       clr [2];
   logic       vld [2];
   logic [7:0] dat [2];
   logic       pe  [2];
   logic       fe  [2];
   logic       brk [2];
   logic       ov  [2];
   logic [2:0] lvl [2];

   int          vectors;
   int          miscompares;
   int unsigned cyc;
   int unsigned last_due;
   int unsigned t0;
   bit          done;
   ent_t        pq  [2][$];
   ent_t        fq  [2][$];
   bit          ovm [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_rx_fifo dut_a (
      .clk(clk), .resetn(resetn), .uart_rxd(rxd[0]),
      .rx_valid(vld[0]), .rx_ready(rdy[0]), .rx_data(dat[0]),
      .rx_parity_err(pe[0]), .rx_frame_err(fe[0]), .rx_break(brk[0]),
      .rx_overrun(ov[0]), .overrun_clr(clr[0]), .fifo_level(lvl[0])
   );

   uart_rx_fifo #(
      .CLK_HZ(1_600_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8), .STOP_BITS(2),
      .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)
   ) dut_b (
      .clk(clk), .resetn(resetn), .uart_rxd(rxd[1]),
      .rx_valid(vld[1]), .rx_ready(rdy[1]), .rx_data(dat[1]),
      .rx_parity_err(pe[1]), .rx_frame_err(fe[1]), .rx_break(brk[1]),
      .rx_overrun(ov[1]), .overrun_clr(clr[1]), .fifo_level(lvl[1])
   );

   function automatic int cpb(input int i);
      return (i == 0) ? 86 : 16;
   endfunction
   function automatic int mid(input int i);
      return (i == 0) ? 43 : 8;
   endfunction
   function automatic int pen(input int i);
      return (i == 0) ? 0 : 1;
   endfunction
   function automatic int nstop(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         if (miscompares <= 40)
            $display("FAIL %s[%0d] @cyc %0d: got 0x%0h, expected 0x%0h", name, i, cyc, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Schedules the expected entry at its push cycle, then drives the frame bit by bit.
   task automatic send_frame(input int i, input logic [7:0] d, input logic par, input logic [1:0] stops);
      ent_t e;
      e.data = d;
      e.pe   = (pen(i) != 0) ? ^{d, par} : 1'b0;
      e.fe   = !stops[0] || (nstop(i) == 2 && !stops[1]);
      e.brk  = e.fe && (d == 8'h00) && (pen(i) == 0 || !par);
      e.due  = cyc + 4 + mid(i) + (8 + pen(i) + nstop(i)) * cpb(i);
      pq[i].push_back(e);
      last_due = e.due;
      rxd[i] = 1'b0;
      tick(cpb(i));
      for (int k = 0; k < 8; k++) begin
         rxd[i] = d[k];
         tick(cpb(i));
      end
      if (pen(i) != 0) begin
         rxd[i] = par;
         tick(cpb(i));
      end
      for (int s = 0; s < nstop(i); s++) begin
         rxd[i] = stops[s];
         tick(cpb(i));
      end
      rxd[i] = 1'b1;
   endtask

   task automatic send_break(input int i, input int nbits);
      ent_t e;
      e.data = 8'h00;
      e.pe   = 1'b0;
      e.fe   = 1'b1;
      e.brk  = 1'b1;
      e.due  = cyc + 4 + mid(i) + (8 + pen(i) + nstop(i)) * cpb(i);
      pq[i].push_back(e);
      rxd[i] = 1'b0;
      tick(nbits * cpb(i));
      rxd[i] = 1'b1;
   endtask

   // Model update at each active edge, then compare on the falling edge.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            bit   pop_m;
            bit   set_m;
            bit   full_m;
            ent_t e;
            if (!resetn) begin
               fq[i].delete();
               pq[i].delete();
               ovm[i] = 1'b0;
            end else begin
               full_m = (fq[i].size() == DEPTH);
               pop_m  = (fq[i].size() > 0) && rdy[i];
               set_m  = 1'b0;
               if (pop_m) fq[i].delete(0);
               while (pq[i].size() > 0 && pq[i][0].due <= cyc) begin
                  e = pq[i][0];
                  pq[i].delete(0);
                  if (full_m && !pop_m) set_m = 1'b1;
                  else fq[i].push_back(e);
               end
               if (set_m) ovm[i] = 1'b1;
               else if (clr[i]) ovm[i] = 1'b0;
            end
         end
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            check("rx_valid", i, 32'(vld[i]), 32'(fq[i].size() > 0));
            check("fifo_level", i, 32'(lvl[i]), 32'(fq[i].size()));
            check("rx_overrun", i, 32'(ov[i]), 32'(ovm[i]));
            if (fq[i].size() > 0) begin
               check("rx_data", i, 32'(dat[i]), 32'(fq[i][0].data));
               check("rx_parity_err", i, 32'(pe[i]), 32'(fq[i][0].pe));
               check("rx_frame_err", i, 32'(fe[i]), 32'(fq[i][0].fe));
               check("rx_break", i, 32'(brk[i]), 32'(fq[i][0].brk));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish by 100000 cycles, required completion");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0;
      rxd = '{1'b1, 1'b1};
      rdy = '{1'b0, 1'b0};
      clr = '{1'b0, 1'b0};
      tick(3);
      resetn = 1'b1;
      tick(2);
      check("reset_valid", 0, 32'(vld[0]), 32'd0);
      check("reset_level", 0, 32'(lvl[0]), 32'd0);
      check("reset_overrun", 0, 32'(ov[0]), 32'd0);
      check("reset_data", 0, 32'({dat[0], pe[0], fe[0], brk[0]}), 32'd0);
      check("reset_level", 1, 32'(lvl[1]), 32'd0);

      // Latency of 0xA5 on the default instance, drained immediately.
      rdy[0] = 1'b1;
      t0 = cyc;
      fork
         send_frame(0, 8'hA5, 1'b0, 2'b11);
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (!vld[0] && n < 2000) begin
               @(negedge clk);
               n++;
            end
            check("a5_latency", 0, cyc - t0, 32'd821);
            check("a5_data", 0, 32'(dat[0]), 32'h0A5);
            check("a5_errs", 0, 32'({pe[0], fe[0], brk[0]}), 32'd0);
            @(negedge clk);
            check("a5_one_cycle", 0, 32'(vld[0]), 32'd0);
         end
      join
      tick(50);

      // Framing error with a non-zero payload.
      rdy[0] = 1'b0;
      send_frame(0, 8'h3C, 1'b0, 2'b00);
      tick(86);
      check("ferr_level", 0, 32'(lvl[0]), 32'd1);
      check("ferr_data", 0, 32'(dat[0]), 32'h03C);
      check("ferr_flags", 0, 32'({pe[0], fe[0], brk[0]}), 32'b010);
      rdy[0] = 1'b1;
      tick(1);
      rdy[0] = 1'b0;
      tick(20);

      // Long break yields exactly one entry.
      send_break(0, 12);
      tick(3 * 86);
      check("break_level", 0, 32'(lvl[0]), 32'd1);
      check("break_data", 0, 32'(dat[0]), 32'd0);
      check("break_flags", 0, 32'({pe[0], fe[0], brk[0]}), 32'b011);
      rdy[0] = 1'b1;
      tick(1);
      rdy[0] = 1'b0;

      // Glitch shorter than half a bit.
      rxd[0] = 1'b0;
      tick(20);
      rxd[0] = 1'b1;
      tick(200);
      check("glitch_level", 0, 32'(lvl[0]), 32'd0);

      // Reset during data bit 3 of an all-ones frame.
      fork
         send_frame(0, 8'hFF, 1'b0, 2'b11);
         begin
            tick(86 * 4 + 40);
            resetn = 1'b0;
            tick(2);
            resetn = 1'b1;
         end
      join
      tick(50);
      check("rst_valid", 0, 32'(vld[0]), 32'd0);
      check("rst_level", 0, 32'(lvl[0]), 32'd0);
      send_frame(0, 8'h5A, 1'b0, 2'b11);
      tick(86);
      check("post_rst_level", 0, 32'(lvl[0]), 32'd1);
      check("post_rst_data", 0, 32'(dat[0]), 32'h05A);
      check("post_rst_errs", 0, 32'({pe[0], fe[0], brk[0]}), 32'd0);
      rdy[0] = 1'b1;
      tick(1);
      rdy[0] = 1'b0;

      // Even parity on instance 1.
      send_frame(1, 8'h01, 1'b1, 2'b11);
      send_frame(1, 8'h01, 1'b0, 2'b11);
      tick(16);
      check("par_level", 1, 32'(lvl[1]), 32'd2);
      check("par_ok_data", 1, 32'(dat[1]), 32'h001);
      check("par_ok_err", 1, 32'(pe[1]), 32'd0);
      rdy[1] = 1'b1;
      tick(1);
      rdy[1] = 1'b0;
      check("par_bad_err", 1, 32'(pe[1]), 32'd1);
      rdy[1] = 1'b1;
      tick(1);
      rdy[1] = 1'b0;

      // Overrun: five frames into a four-entry FIFO.
      for (int v = 8'h10; v <= 8'h14; v++) begin
         logic [7:0] d;
         d = 8'(v);
         send_frame(1, d, ^d, 2'b11);
      end
      tick(16);
      check("ovr_level", 1, 32'(lvl[1]), 32'd4);
      check("ovr_flag", 1, 32'(ov[1]), 32'd1);
      rdy[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("ovr_pop_valid", 1, 32'(vld[1]), 32'd1);
         check("ovr_pop_data", 1, 32'(dat[1]), 32'h10 + 32'(k));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("ovr_drained", 1, 32'(vld[1]), 32'd0);
      @(posedge clk);
      #1;
      rdy[1] = 1'b0;
      clr[1] = 1'b1;
      tick(1);
      clr[1] = 1'b0;
      check("ovr_cleared", 1, 32'(ov[1]), 32'd0);

      // Clear coinciding with a dropped push: the set must win.
      for (int v = 8'h20; v <= 8'h23; v++) begin
         logic [7:0] d;
         d = 8'(v);
         send_frame(1, d, ^d, 2'b11);
      end
      last_due = 0;
      fork
         send_frame(1, 8'h24, 1'b0, 2'b11);
         begin
            int n;
            n = 0;
            while (!(last_due != 0 && cyc == last_due - 1) && n < 1000) begin
               @(posedge clk);
               #1;
               n++;
            end
            clr[1] = 1'b1;
            tick(1);
            clr[1] = 1'b0;
         end
      join
      tick(2);
      check("ovr_set_wins", 1, 32'(ov[1]), 32'd1);
      check("ovr_set_level", 1, 32'(lvl[1]), 32'd4);
      rdy[1] = 1'b1;
      tick(6);
      rdy[1] = 1'b0;
      clr[1] = 1'b1;
      tick(1);
      clr[1] = 1'b0;

      // Random frames with random drain and clears.
      done = 1'b0;
      fork
         begin
            for (int f = 0; f < 30; f++) begin
               logic [7:0] d;
               logic       p;
               logic [1:0] s;
               int         k;
               k = int'($urandom_range(0, 9));
               d = 8'($urandom);
               p = ^d;
               s = 2'b11;
               if (k == 0) begin
                  d = 8'h00;
                  p = 1'b0;
                  s = 2'($urandom_range(0, 2));
               end else if (k == 1) begin
                  p = ~p;
               end else if (k == 2) begin
                  s = 2'($urandom_range(0, 2));
               end
               send_frame(1, d, p, s);
               tick(16 + int'($urandom_range(0, 16)));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               rdy[1] = 1'($urandom_range(0, 1));
               clr[1] = ($urandom_range(0, 19) == 0);
               tick(1);
            end
         end
      join
      clr[1] = 1'b0;
      rdy[1] = 1'b1;
      tick(20);
      check("final_level", 1, 32'(lvl[1]), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
